// File: rtl/data_memory_hs.sv
// Word-organised data RAM behind a req/ready handshake: byte-lane writes, configurable
// access latency, a one-cycle completion pulse and an error response for bad addresses.
module data_memory_hs #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned BYTE_ADDR = 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic                ready_o,
    output logic                done_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o
);
    localparam int unsigned NB       = DATA_W / 8;
    localparam int unsigned SHIFT    = (BYTE_ADDR != 0 && NB > 1) ? $clog2(NB) : 0;
    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]  CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    if (LATENCY == 0 || LATENCY > 8) begin : g_bad_latency
        $error("data_memory_hs: LATENCY must be in 1..8");
    end
    if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_bad_data_w
        $error("data_memory_hs: DATA_W must be a nonzero multiple of 8");
    end
    if (DEPTH == 0 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("data_memory_hs: DEPTH must be a power of two");
    end

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NB-1:0]       be_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                accept, access, mem_we;
    logic                acc_we, acc_misaligned, acc_err;
    logic [ADDR_W-1:0]   acc_addr, acc_word;
    logic [DATA_W-1:0]   acc_wdata;
    logic [NB-1:0]       acc_be;
    logic [IDX_W-1:0]    acc_idx;

    assign ready_o = (state_q != StWait);
    assign done_o  = (state_q == StDone);
    assign err_o   = done_o & err_q;
    assign rdata_o = rdata_q;
    assign accept  = req_i & ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StWait: begin
                if (cnt_q == 3'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = StDone;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // With LATENCY=1 the access happens on the accept edge itself, so it uses the live inputs.
    always_comb begin
        if (state_q == StWait) begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end else begin
            acc_we    = we_i;
            acc_addr  = addr_i;
            acc_wdata = wdata_i;
            acc_be    = be_i;
        end
    end

    if (SHIFT > 0) begin : g_align
        assign acc_misaligned = |acc_addr[SHIFT-1:0];
    end else begin : g_no_align
        assign acc_misaligned = 1'b0;
    end

    assign acc_word = acc_addr >> SHIFT;
    assign acc_err  = acc_misaligned | ({1'b0, acc_word} >= DEPTH_L);
    assign acc_idx  = acc_word[IDX_W-1:0];
    assign access   = (state_d == StDone);
    // Writes are suppressed while reset is held so an abandoned request never lands.
    assign mem_we   = access & acc_we & ~acc_err & rst_n_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                be_q    <= be_i;
            end
            if (access) begin
                err_q <= acc_err;
                if (acc_err) begin
                    rdata_q <= '0;
                end else if (!acc_we) begin
                    rdata_q <= mem_q[acc_idx];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (acc_be[b]) begin
                    mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: three instances (LATENCY 1, 3, 4) each checked every cycle
// against a transaction-level model, plus directed literal checks.
module tb_data_memory_hs;
    localparam int NI = 3;

    logic        clk;
    logic        rst_n;
    logic        req   [NI];
    logic        we    [NI];
    logic [31:0] addr  [NI];
    logic [31:0] wdata [NI];
    logic [3:0]  be    [NI];
    logic        ready [NI];
    logic        done  [NI];
    logic        err   [NI];
    logic [31:0] rdata [NI];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

        data_memory_hs #(
            .DATA_W   (32),
            .ADDR_W   (32),
            .DEPTH    (256),
            .LATENCY  (L),
            .BYTE_ADDR(1)
        ) u_dut (
            .clk_i  (clk),
            .rst_n_i(rst_n),
            .req_i  (req[g]),
            .we_i   (we[g]),
            .addr_i (addr[g]),
            .wdata_i(wdata[g]),
            .be_i   (be[g]),
            .ready_o(ready[g]),
            .done_o (done[g]),
            .rdata_o(rdata[g]),
            .err_o  (err[g])
        );

        // Model: one outstanding request completing L cycles after it is presented.
        logic [31:0] mdl_mem [256];
        bit          pend;
        int          due, cyc;
        bit          p_we;
        logic [31:0] p_addr, p_wdata, exp_rdata;
        logic [3:0]  p_be;

        initial begin
            foreach (mdl_mem[i]) mdl_mem[i] = 'x;
            pend      = 0;
            cyc       = 0;
            due       = 0;
            exp_rdata = '0;
        end

        always @(negedge clk) begin
            bit          e_done, e_err;
            int unsigned w;
            e_done = 0;
            e_err  = 0;
            if (pend && due == cyc) begin
                e_done = 1;
                pend   = 0;
                w      = p_addr / 4;
                if ((p_addr % 4) != 0 || w >= 256) begin
                    e_err     = 1;
                    exp_rdata = '0;
                end else if (p_we) begin
                    for (int b = 0; b < 4; b++)
                        if (p_be[b]) mdl_mem[w][8*b +: 8] = p_wdata[8*b +: 8];
                end else begin
                    exp_rdata = mdl_mem[w];
                end
            end
            if (!rst_n) begin
                pend      = 0;
                e_done    = 0;
                e_err     = 0;
                exp_rdata = '0;
            end
            chk($sformatf("L%0d ready c%0d", L, cyc), {31'b0, ready[g]}, {31'b0, !pend});
            chk($sformatf("L%0d done c%0d", L, cyc), {31'b0, done[g]}, {31'b0, e_done});
            chk($sformatf("L%0d err c%0d", L, cyc), {31'b0, err[g]}, {31'b0, e_err});
            if (!$isunknown(exp_rdata))
                chk($sformatf("L%0d rdata c%0d", L, cyc), rdata[g], exp_rdata);
            if (rst_n && req[g] && !pend) begin
                pend    = 1;
                due     = cyc + L;
                p_we    = we[g];
                p_addr  = addr[g];
                p_wdata = wdata[g];
                p_be    = be[g];
            end
            cyc++;
        end
    end

    task automatic xact(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd, output logic e,
                        output int lat);
        int n;
        @(posedge clk);
        #1;
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
        n = 0;
        @(negedge clk);
        while (!ready[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("xact ready wait", 32'(n < 20), 32'd1);
        @(posedge clk);
        #1;
        req[k] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done[k] && lat < 20);
        rd = rdata[k];
        e  = err[k];
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        if (r == 1) return 32'h400 + 32'($urandom_range(0, 63) * 4);
        return 32'($urandom_range(0, 15) * 4);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0; be[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back write then read on the single-cycle instance.
        @(posedge clk);
        #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'hDEADBEEF; be[0] = 4'hF;
        @(posedge clk);
        #1 we[0] = 1'b0;
        @(negedge clk);
        chk("t1 write done", {31'b0, done[0]}, 32'd1);
        chk("t1 write err", {31'b0, err[0]}, 32'd0);
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(negedge clk);
        chk("t1 read done", {31'b0, done[0]}, 32'd1);
        chk("t1 read data", rdata[0], 32'hDEADBEEF);
        chk("t1 read err", {31'b0, err[0]}, 32'd0);

        // Byte enables on the LATENCY=4 instance.
        xact(2, 1, 32'h20, 32'h11223344, 4'hF, rd, e, lat);
        chk("t2 latency", 32'(lat), 32'd4);
        xact(2, 1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, e, lat);
        xact(2, 0, 32'h20, 32'h0, 4'h0, rd, e, lat);
        chk("t2 merged data", rd, 32'h11BB33DD);

        // Request held through WAIT is not taken again.
        @(posedge clk);
        #1;
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h20;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            if (c == 4) req[2] = 1'b0;
            @(negedge clk);
            chk($sformatf("t3 ready c%0d", c), {31'b0, ready[2]}, 32'(c >= 4));
            chk($sformatf("t3 done c%0d", c), {31'b0, done[2]}, 32'(c == 4));
        end
        chk("t3 data", rdata[2], 32'h11BB33DD);

        // Error responses.
        xact(0, 1, 32'h0, 32'hCAFEF00D, 4'hF, rd, e, lat);
        xact(0, 0, 32'h22, 32'h0, 4'h0, rd, e, lat);
        chk("t4 misaligned err", {31'b0, e}, 32'd1);
        chk("t4 misaligned rdata", rd, 32'h0);
        chk("t4 misaligned latency", 32'(lat), 32'd1);
        xact(0, 1, 32'h400, 32'h55555555, 4'hF, rd, e, lat);
        chk("t4 range err", {31'b0, e}, 32'd1);
        xact(0, 0, 32'h0, 32'h0, 4'h0, rd, e, lat);
        chk("t4 word0 err", {31'b0, e}, 32'd0);
        chk("t4 word0 data", rd, 32'hCAFEF00D);

        // Reset abandons an in-flight write on the LATENCY=3 instance.
        xact(1, 1, 32'h8, 32'h00000077, 4'hF, rd, e, lat);
        chk("t5 latency", 32'(lat), 32'd3);
        @(posedge clk);
        #1;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h8; wdata[1] = 32'h5; be[1] = 4'hF;
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        chk("t5 reset ready", {31'b0, ready[1]}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t5 no done", {31'b0, done[1]}, 32'd0);
        end
        xact(1, 0, 32'h8, 32'h0, 4'h0, rd, e, lat);
        chk("t5 kept data", rd, 32'h00000077);

        // be=0 write is a normal no-op completion.
        xact(1, 1, 32'h30, 32'h12345678, 4'hF, rd, e, lat);
        xact(1, 1, 32'h30, 32'hFFFFFFFF, 4'h0, rd, e, lat);
        chk("t6 noop latency", 32'(lat), 32'd3);
        chk("t6 noop err", {31'b0, e}, 32'd0);
        xact(1, 0, 32'h30, 32'h0, 4'h0, rd, e, lat);
        chk("t6 data", rd, 32'h12345678);

        // Random traffic on all instances, occasional one-cycle reset pulses.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            rst_n = ($urandom_range(0, 399) != 0);
            for (int k = 0; k < NI; k++) begin
                req[k]   = ($urandom_range(0, 2) != 0);
                we[k]    = 1'($urandom_range(0, 1));
                addr[k]  = rand_addr();
                wdata[k] = $urandom;
                be[k]    = 4'($urandom_range(0, 15));
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < NI; k++) req[k] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_memory_hs.md
Name: data_memory_hs

Overview:
Parametrised successor to the pipeline's single-cycle data memory. It is a synchronous, word-organised RAM behind a request/ready handshake, with these additions:
- byte-lane write enables
- configurable access latency
- a completion pulse
- an error response for misaligned or out-of-range addresses

It sits in the MEM stage, and the pipeline stalls on ready_o/done_o.

Parameters:
DATA_W, 32, data word width in bits; multiple of 8
ADDR_W, 32, address width in bits
DEPTH, 256, number of words; power of two
LATENCY, 1, cycles from request acceptance to completion; legal range 1..8
BYTE_ADDR, 1, 1 = addr_i is a byte address (word index = addr_i >> log2(DATA_W/8)); 0 = addr_i is a word index

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
req_i  input  1  access request
we_i  input  1  1 = write, 0 = read
addr_i  input  ADDR_W  access address
wdata_i  input  DATA_W  write data
be_i  input  DATA_W/8  byte-lane write enables; bit n covers wdata_i[8n+7:8n]
ready_o  output  1  block can accept a request this cycle
done_o  output  1  one-cycle completion pulse
rdata_o  output  DATA_W  read data; valid while done_o=1 on a read
err_o  output  1  completion carried an error; valid only with done_o

Behaviour:
- Reset is asynchronous active-low (rst_n_i), and the block runs on the single clock clk_i.
- Reset values: state=IDLE, ready_o=1, done_o=0, err_o=0, rdata_o=0, latency counter=0.
- Memory contents are not reset.
- FSM states are IDLE, WAIT and DONE.
- ready_o=1 in IDLE and DONE; ready_o=0 in WAIT.
- Acceptance: req_i & ready_o at a rising edge. The edge captures we_i, addr_i, wdata_i and be_i into request registers; inputs are don't-care afterwards.
- On accept with LATENCY=1: go to DONE.
- On accept with LATENCY>1: go to WAIT and load counter with LATENCY-2.
- In WAIT: decrement the counter each cycle; at 0 go to DONE.
- The memory access happens on the edge that enters DONE. done_o is therefore high exactly LATENCY cycles after the accept edge.
- In DONE: done_o=1 for one cycle.
  - If a new request is accepted in this cycle, follow the accept rules above (back-to-back; LATENCY=1 gives one access per cycle).
  - Otherwise go to IDLE.
- Error check, applied to the captured address:
  - BYTE_ADDR=1 and the low log2(DATA_W/8) bits are nonzero (misaligned); or
  - the word index is >= DEPTH.
  - On error: no memory read or write, err_o=1 with done_o, rdata_o=0.
- Write, no error: for each set bit of be_i, the corresponding byte of memory[index] is replaced; other bytes are kept. be_i=0 is a legal no-op write that completes normally with err_o=0. rdata_o holds its previous value.
- Read, no error: rdata_o = memory[index] as of the access edge, and holds until the next completion.
- err_o is 0 whenever done_o=0.
- Ordering: a read accepted in the DONE cycle of a write to the same word returns the newly written data.
- Reset mid-operation (WAIT or DONE-entry pending): the request is abandoned and no memory write occurs. done_o is not pulsed, and outputs return to their reset values immediately.
- req_i with ready_o=0 is ignored; there is no queueing. The requester must hold req_i until it sees ready_o.
- Elaboration fails on illegal parameters: LATENCY outside 1..8, DATA_W not a multiple of 8, or DEPTH not a power of two.

Test Plan:
1. Reset, then LATENCY=1: write 0xDEADBEEF to addr 0x10 with be=4'hF, then read 0x10 back-to-back. Required: done_o high on both consecutive cycles after each accept, rdata_o=0xDEADBEEF, err_o=0.
2. Byte enables: write 0x11223344 to 0x20 with be=F, then write 0xAABBCCDD with be=4'b0101, then read 0x20. Required: rdata_o=0x11BB33DD.
3. LATENCY=4: read request at cycle 0. Required: ready_o=0 during cycles 1-3, done_o=1 only in cycle 4, ready_o=1 in cycle 4; req_i held during WAIT is not accepted.
4. Errors: read 0x22 (misaligned) and write 0x400 with DEPTH=256. Required: done_o with err_o=1, rdata_o=0, and a later read of word 0 is unchanged.
5. LATENCY=3: accept a write of 0x5 to 0x8, assert rst_n_i low in cycle 1, release, then read 0x8. Required: done_o never pulses for the aborted write, and the value at 0x8 is the pre-reset value.
6. be=0 write of 0xFFFFFFFF to 0x30 holding 0x12345678, then read. Required: done_o=1, err_o=0, rdata_o=0x12345678.
